demux4_stage: RTL and testbench

//  Registered 1-to-4 demultiplexer stage with valid/ready handshake; routes one
//  W-bit word per transfer to the destination chosen by a 2-bit selector.

---
 rtl/demux4_stage_if.sv | 36 +++
 rtl/demux4_stage.sv | 142 ++++++++++++++
 tb/tb_demux4_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/demux4_stage_if.sv
// Handshake bundle for demux4_stage: one producer port, four consumer ports
// sharing a single data/select bus.
interface demux4_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       select;
  logic [WIDTH-1:0] data_i;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       out_sel;

  modport master (
    output in_valid,
    output select,
    output data_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_o,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  select,
    input  data_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_o,
    output out_sel
  );
endinterface

// File: rtl/demux4_stage.sv
// Registered 1-to-4 demux stage with valid/ready handshake.
// Define DEMUX4_SKID_EN for a skid entry and a registered in_ready.
module demux4_stage #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  demux4_stage_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } hold_t;

  hold_t hr_q, hr_d;
  hold_t in_word;
  logic  drain;
  logic  fire_in;

  assign in_word = {1'b1, bus.select, bus.data_i};
  assign drain   = hr_q.valid & bus.out_ready[hr_q.sel];
  assign fire_in = bus.in_valid & bus.in_ready;

  assign bus.out_valid = hr_q.valid
                       ? (4'b0001 << hr_q.sel)
                       : 4'b0000;
  assign bus.data_o    = hr_q.data;
  assign bus.out_sel   = hr_q.sel;

`ifdef DEMUX4_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  hold_t  sk_q, sk_d;
  logic   rdy_q, rdy_d;

  assign bus.in_ready = rdy_q;

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    sk_d    = sk_q;
    unique case (state_q)
      EMPTY: begin
        if (fire_in) begin
          hr_d    = in_word;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          fire_in & drain: begin
            hr_d = in_word;
          end
          fire_in & !drain: begin
            sk_d    = in_word;
            state_d = TWO;
          end
          !fire_in & drain: begin
            hr_d.valid = 1'b0;
            state_d    = EMPTY;
          end
          default: ;
        endcase
      end
      TWO: begin
        // in_ready is low here, so only a drain can move
        if (drain) begin
          hr_d       = sk_q;
          sk_d.valid = 1'b0;
          state_d    = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        hr_d    = '0;
        sk_d    = '0;
      end
    endcase
    rdy_d = !sk_d.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hr_q    <= '0;
      sk_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hr_q    <= hr_d;
      sk_q    <= sk_d;
      rdy_q   <= rdy_d;
    end
  end

`else

  // drain and fill in the same cycle reload HR with no bubble
  assign bus.in_ready = !hr_q.valid
                      | bus.out_ready[hr_q.sel];

  always_comb begin
    hr_d = hr_q;
    if (fire_in) begin
      hr_d = in_word;
    end else if (drain) begin
      hr_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= '0;
    end else begin
      hr_q <= hr_d;
    end
  end

`endif

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(bus.out_valid)
  );

  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (|bus.out_valid && !(|(bus.out_valid & bus.out_ready)))
    |=> ($stable(bus.data_o) && $stable(bus.out_sel))
  );
`endif

endmodule

// File: tb/tb_demux4_stage.sv
// Directed bench for demux4_stage: reset, routing, stall,
// wrong-ready, throughput and (when enabled) skid behaviour.
module tb_demux4_stage;

  localparam int W = 32;
`ifdef DEMUX4_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  demux4_stage_if #(.WIDTH(W)) bus ();

  demux4_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.select   = s;
    bus.data_i   = d;
  endtask

  logic [31:0] td [100];
  logic [1:0]  ts [100];
  int          n_out;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.select    = 2'd0;
    bus.data_i    = '0;
    bus.out_ready = 4'h0;

    // power-on reset
    #2;
    check("por_ov", bus.out_valid, 0);
    check("por_data", bus.data_o, 0);
    check("por_sel", bus.out_sel, 0);
    check("por_rdy", bus.in_ready, SKID ? 0 : 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("rel_rdy", bus.in_ready, 1);

    // route one word to each destination
    bus.out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send(i[1:0], 32'hA0 + i);
      tick;
      check("route",
            {bus.out_valid, bus.out_sel, bus.data_o},
            {4'b0001 << i, i[1:0], 32'hA0 + i});
    end
    bus.in_valid = 1'b0;
    tick;
    check("route_end", bus.out_valid, 0);

    // stall destination 2
    bus.out_ready = 4'b1011;
    send(2'd2, 32'h1234);
    tick;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_ov", bus.out_valid, 4'b0100);
      check("stall_data", bus.data_o, 32'h1234);
      check("stall_rdy", bus.in_ready, SKID ? 1 : 0);
      tick;
    end
    bus.out_ready = 4'b0100;
    #1;
    check("stall_rel_rdy", bus.in_ready, 1);
    tick;
    check("stall_drain", bus.out_valid, 0);

    // ready on the wrong destinations only
    bus.out_ready = 4'h0;
    send(2'd1, 32'h55);
    tick;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      check("wrong_rdy",
            {bus.out_valid, bus.out_sel, bus.data_o},
            {4'b0010, 2'd1, 32'h55});
      tick;
    end
    bus.out_ready = 4'b0010;
    tick;
    check("wrong_drain", bus.out_valid, 0);

    // asynchronous reset with HR full
    bus.out_ready = 4'h0;
    send(2'd3, 32'hDEAD);
    tick;
    bus.in_valid = 1'b0;
    check("mid_ov", bus.out_valid, 4'b1000);
    check("mid_data", bus.data_o, 32'hDEAD);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ov", bus.out_valid, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_sel", bus.out_sel, 0);
    check("rst_rdy", bus.in_ready, SKID ? 0 : 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("rst_rel_rdy", bus.in_ready, 1);
    check("rst_rel_ov", bus.out_valid, 0);

    // back-to-back throughput, all consumers ready
    for (int i = 0; i < 100; i++) begin
      td[i] = $urandom;
      ts[i] = 2'($urandom_range(0, 3));
    end
    bus.out_ready = 4'hF;
    n_out = 0;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        send(ts[c], td[c]);
        #1;
        check("thru_rdy", bus.in_ready, 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick;
      if (bus.out_valid != 4'h0) n_out++;
      if (c < 100) begin
        check("thru",
              {bus.out_valid, bus.out_sel, bus.data_o},
              {4'b0001 << ts[c], ts[c], td[c]});
      end
    end
    check("thru_cnt", n_out, 100);
    check("thru_end", bus.out_valid, 0);

`ifdef DEMUX4_SKID_EN
    // two words against a stalled consumer
    bus.out_ready = 4'h0;
    send(2'd0, 32'h111);
    #1;
    check("sk_rdy0", bus.in_ready, 1);
    tick;
    check("sk_ov1", bus.out_valid, 4'b0001);
    check("sk_rdy1", bus.in_ready, 1);
    send(2'd0, 32'h222);
    tick;
    bus.in_valid = 1'b0;
    check("sk_rdy2", bus.in_ready, 0);
    check("sk_data2", bus.data_o, 32'h111);
    tick;
    check("sk_hold_rdy", bus.in_ready, 0);
    check("sk_hold_data", bus.data_o, 32'h111);
    bus.out_ready = 4'b0001;
    tick;
    check("sk_ov3", bus.out_valid, 4'b0001);
    check("sk_data3", bus.data_o, 32'h222);
    check("sk_rdy3", bus.in_ready, 1);
    tick;
    check("sk_end", bus.out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
